// File: rtl/mips_core_pkg.sv
// Shared encodings for the single-cycle MIPS core: opcodes, functs, ALU ops, register indices.
package mips_core_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned NREGS  = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [4:0] ZERO = 5'd0;
    localparam logic [4:0] RA   = 5'd31;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_LUI
    } alu_op_e;

    // Shifts take the amount from the shamt field; LUI moves the immediate to the upper half.
    function automatic logic [31:0] alu_eval(input alu_op_e op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [4:0] shamt);
        logic [31:0] y;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_NOR:  y = ~(a | b);
            ALU_SLT:  y = 32'($signed(a) < $signed(b));
            ALU_SLTU: y = 32'(a < b);
            ALU_SLL:  y = b << shamt;
            ALU_SRL:  y = b >> shamt;
            ALU_LUI:  y = {b[15:0], 16'h0000};
            default:  y = 32'h0;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write port, $0 hardwired to zero.
module mips_regfile
    import mips_core_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1_c,
    output logic [31:0] rd2_c
);

    logic [31:0] Registers [0:NREGS-1];

    // Reads see the value from before this cycle's write.
    assign rd1_c = (ra1 == ZERO) ? 32'h0 : Registers[ra1];
    assign rd2_c = (ra2 == ZERO) ? 32'h0 : Registers[ra2];

    // Register storage; reset clears every entry, writes to $0 are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) Registers[i] <= 32'h0;
        end else if (we && (wa != ZERO)) begin
            Registers[wa] <= wd;
        end
    end

endmodule

// File: rtl/mips_core.sv
// Single-cycle MIPS core with internal instruction and data memories.
// Optional feature macro: MIPS_CORE_JAL_EN enables jal/jr; without it both decode as NOPs.
module mips_core
    import mips_core_pkg::*;
#(
    parameter int unsigned IM_WORDS = 256,
    parameter int unsigned DM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc
);

    localparam int unsigned IM_AW = (IM_WORDS > 1) ? $clog2(IM_WORDS) : 1;
    localparam int unsigned DM_AW = (DM_BYTES > 1) ? $clog2(DM_BYTES) : 1;

    logic [31:0] InstructionMemory [0:IM_WORDS-1];
    logic [7:0]  DataMemory        [0:DM_BYTES-1];

    logic [31:0]      instr, pc_plus4, pc_next, imm_ext, alu_b, alu_y, wd, dm_rdata;
    logic [31:0]      rs_data, rt_data, br_target, j_target;
    logic [IM_AW-1:0] im_idx;
    logic [DM_AW-1:0] dm_base;
    logic [5:0]       op, funct;
    logic [4:0]       rs, rt, rd, shamt, wa;
    logic [15:0]      imm;
    logic [25:0]      target;
    logic             reg_we, use_imm, zext, mem_we, mem_rd, is_beq, is_bne, is_j, is_jr, link;
    alu_op_e          alu_op;

    // Fetch and field split.
    assign im_idx = IM_AW'((pc >> 2) % 32'(IM_WORDS));
    assign instr  = InstructionMemory[im_idx];
    assign op     = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign imm    = instr[15:0];
    assign target = instr[25:0];

    // Decode: defaults describe a NOP, each recognised instruction switches on what it needs.
    always_comb begin
        reg_we  = 1'b0;
        use_imm = 1'b0;
        zext    = 1'b0;
        mem_we  = 1'b0;
        mem_rd  = 1'b0;
        is_beq  = 1'b0;
        is_bne  = 1'b0;
        is_j    = 1'b0;
        is_jr   = 1'b0;
        link    = 1'b0;
        wa      = rd;
        alu_op  = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                reg_we = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:          alu_op = ALU_AND;
                    FN_OR:           alu_op = ALU_OR;
                    FN_XOR:          alu_op = ALU_XOR;
                    FN_NOR:          alu_op = ALU_NOR;
                    FN_SLT:          alu_op = ALU_SLT;
                    FN_SLTU:         alu_op = ALU_SLTU;
                    FN_SLL:          alu_op = ALU_SLL;
                    FN_SRL:          alu_op = ALU_SRL;
`ifdef MIPS_CORE_JAL_EN
                    FN_JR: begin
                        reg_we = 1'b0;
                        is_jr  = 1'b1;
                    end
`endif
                    default:         reg_we = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin reg_we = 1'b1; use_imm = 1'b1; wa = rt; end
            OP_SLTI: begin reg_we = 1'b1; use_imm = 1'b1; wa = rt; alu_op = ALU_SLT; end
            OP_ANDI: begin reg_we = 1'b1; use_imm = 1'b1; zext = 1'b1; wa = rt; alu_op = ALU_AND; end
            OP_ORI:  begin reg_we = 1'b1; use_imm = 1'b1; zext = 1'b1; wa = rt; alu_op = ALU_OR; end
            OP_XORI: begin reg_we = 1'b1; use_imm = 1'b1; zext = 1'b1; wa = rt; alu_op = ALU_XOR; end
            OP_LUI:  begin reg_we = 1'b1; use_imm = 1'b1; wa = rt; alu_op = ALU_LUI; end
            OP_LW:   begin reg_we = 1'b1; use_imm = 1'b1; wa = rt; mem_rd = 1'b1; end
            OP_SW:   begin use_imm = 1'b1; mem_we = 1'b1; end
            OP_BEQ:  is_beq = 1'b1;
            OP_BNE:  is_bne = 1'b1;
            OP_J:    is_j = 1'b1;
`ifdef MIPS_CORE_JAL_EN
            OP_JAL:  begin is_j = 1'b1; link = 1'b1; reg_we = 1'b1; wa = RA; end
`endif
            default: ;
        endcase
    end

    mips_regfile u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1   (rs),
        .ra2   (rt),
        .we    (reg_we),
        .wa    (wa),
        .wd    (wd),
        .rd1_c (rs_data),
        .rd2_c (rt_data)
    );

    // Execute, memory read and write-back select.
    assign imm_ext  = zext ? {16'h0000, imm} : {{16{imm[15]}}, imm};
    assign alu_b    = use_imm ? imm_ext : rt_data;
    assign alu_y    = alu_eval(alu_op, rs_data, alu_b, shamt);
    assign dm_base  = DM_AW'((alu_y % 32'(DM_BYTES)) & ~32'd3);
    assign dm_rdata = {DataMemory[dm_base], DataMemory[dm_base + DM_AW'(1)],
                       DataMemory[dm_base + DM_AW'(2)], DataMemory[dm_base + DM_AW'(3)]};
    assign wd       = mem_rd ? dm_rdata : (link ? pc_plus4 : alu_y);

    // Next-pc selection: jr over jump over taken branch over sequential.
    assign pc_plus4  = pc + 32'd4;
    assign br_target = pc_plus4 + {imm_ext[29:0], 2'b00};
    assign j_target  = {pc_plus4[31:28], target, 2'b00};
    always_comb begin
        pc_next = pc_plus4;
        if ((is_beq && (rs_data == rt_data)) || (is_bne && (rs_data != rt_data))) pc_next = br_target;
        if (is_j)  pc_next = j_target;
        if (is_jr) pc_next = rs_data;
    end

    // Program counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= 32'h0;
        else        pc <= pc_next;
    end

    // Big-endian word store; memory contents survive reset, no store is taken while held in reset.
    always_ff @(posedge clk) begin
        if (mem_we && rst_n) begin
            DataMemory[dm_base]               <= rt_data[31:24];
            DataMemory[dm_base + DM_AW'(1)]   <= rt_data[23:16];
            DataMemory[dm_base + DM_AW'(2)]   <= rt_data[15:8];
            DataMemory[dm_base + DM_AW'(3)]   <= rt_data[7:0];
        end
    end

endmodule

// File: tb/tb_mips_core.sv
// Directed bench for mips_core with an expectation queue checked against architectural state.
module tb_mips_core;

    localparam int unsigned IMW = 256;
    localparam int unsigned DMB = 1024;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   pidx   = 0;

    mips_core #(.IM_WORDS(IMW), .DM_BYTES(DMB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pc    (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh,
                                          input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] opc, input int rs, input int rt, input int imm);
        return {opc, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] opc, input int tgt);
        return {opc, 26'(tgt)};
    endfunction

    function automatic logic [31:0] rf(input int i);
        return dut.u_regfile.Registers[i];
    endfunction

    function automatic logic [31:0] dmw(input int a);
        return {dut.DataMemory[a], dut.DataMemory[a+1], dut.DataMemory[a+2], dut.DataMemory[a+3]};
    endfunction

    task automatic expect_val(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sbq.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sbq.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_underflow observed=%h expected=none", obs);
        end else begin
            e = sbq.pop_front();
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    // Hold reset and wipe both memories before loading a new program.
    task automatic begin_prog();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < int'(IMW); i++) dut.InstructionMemory[i] = 32'h0;
        for (int i = 0; i < int'(DMB); i++) dut.DataMemory[i] = 8'h00;
        pidx = 0;
    endtask

    task automatic put(input logic [31:0] w);
        dut.InstructionMemory[pidx] = w;
        pidx++;
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;

        // Basic arithmetic and reset state.
        begin_prog();
        put(enc_i(6'h08, 0, 8, 5));
        put(enc_i(6'h08, 0, 9, -3));
        put(enc_r(8, 9, 10, 0, 6'h20));
        repeat (2) @(posedge clk);
        @(negedge clk);
        expect_val("rst_pc", 32'h0);
        expect_val("rst_r8", 32'h0);
        check(pc);
        check(rf(8));
        release_rst();
        expect_val("add_r8", 32'h5);
        expect_val("add_r9", 32'hFFFF_FFFD);
        expect_val("add_r10", 32'h2);
        expect_val("add_pc", 32'hC);
        run(3);
        check(rf(8)); check(rf(9)); check(rf(10)); check(pc);

        // Loads, stores, store-to-load visibility, address wrap and alignment.
        begin_prog();
        dut.DataMemory[3] = 8'h07;
        put(enc_i(6'h23, 0, 11, 0));
        put(enc_i(6'h2B, 0, 11, 8));
        put(enc_i(6'h08, 0, 13, 16'h1234));
        put(enc_i(6'h2B, 0, 13, 12));
        put(enc_i(6'h23, 0, 14, 12));
        put(enc_i(6'h2B, 0, 13, 1040));
        put(enc_i(6'h23, 0, 15, 19));
        expect_val("lw_r11", 32'h7);
        expect_val("sw_dm8", 32'h7);
        expect_val("sw_dm11_byte", 32'h7);
        expect_val("sw_dm8_byte", 32'h0);
        expect_val("lw_after_sw_r14", 32'h1234);
        expect_val("wrap_dm16", 32'h1234);
        expect_val("unaligned_lw_r15", 32'h1234);
        expect_val("mem_pc", 32'h1C);
        release_rst();
        run(7);
        check(rf(11)); check(dmw(8));
        check(32'(dut.DataMemory[11])); check(32'(dut.DataMemory[8]));
        check(rf(14)); check(dmw(16)); check(rf(15)); check(pc);

        // $0 immutable; beq jumps two instructions past itself.
        begin_prog();
        put(enc_i(6'h08, 0, 0, 9));
        put(enc_i(6'h04, 0, 0, 1));
        put(enc_i(6'h08, 0, 3, 7));
        put(enc_i(6'h08, 0, 4, 4));
        expect_val("r0_zero", 32'h0);
        expect_val("beq_pc", 32'hC);
        expect_val("beq_skip_r3", 32'h0);
        expect_val("beq_tgt_r4", 32'h4);
        release_rst();
        run(2);
        check(rf(0)); check(pc);
        run(1);
        check(rf(3)); check(rf(4));

        // ALU coverage, immediates, bne both ways, unknown encodings as NOPs.
        begin_prog();
        put(enc_i(6'h08, 0, 1, -8));
        put(enc_i(6'h0D, 0, 2, 16'h8001));
        put(enc_i(6'h0C, 1, 3, 16'hFFF0));
        put(enc_i(6'h0E, 1, 4, 16'h00FF));
        put(enc_i(6'h0F, 0, 5, 16'h1234));
        put(enc_i(6'h0A, 1, 6, -7));
        put(enc_r(2, 1, 7, 0, 6'h2B));
        put(enc_r(1, 2, 8, 0, 6'h2A));
        put(enc_r(2, 1, 9, 0, 6'h22));
        put(enc_r(1, 2, 10, 0, 6'h23));
        put(enc_r(1, 2, 11, 0, 6'h24));
        put(enc_r(1, 2, 12, 0, 6'h25));
        put(enc_r(1, 2, 13, 0, 6'h26));
        put(enc_r(1, 2, 14, 0, 6'h27));
        put(enc_r(0, 2, 15, 4, 6'h00));
        put(enc_r(0, 1, 16, 28, 6'h02));
        put(enc_r(5, 2, 17, 0, 6'h21));
        put(enc_i(6'h09, 0, 18, -1));
        put(enc_r(18, 18, 19, 0, 6'h20));
        put(enc_i(6'h05, 0, 0, 5));
        put(enc_i(6'h05, 1, 0, 1));
        put(enc_i(6'h08, 0, 20, 1));
        put(enc_i(6'h3F, 0, 21, 5));
        put(enc_r(1, 2, 22, 0, 6'h3F));
        put(enc_i(6'h08, 0, 23, 23));
        begin
            logic [31:0] alu_exp [1:23];
            alu_exp = '{32'hFFFF_FFF8, 32'h0000_8001, 32'h0000_FFF0, 32'hFFFF_FF07,
                        32'h1234_0000, 32'h1, 32'h1, 32'h1, 32'h0000_8009, 32'hFFFF_7FF7,
                        32'h0000_8000, 32'hFFFF_FFF9, 32'hFFFF_7FF9, 32'h6, 32'h0008_0010,
                        32'hF, 32'h1234_8001, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0, 32'h0,
                        32'h0, 32'd23};
            for (int i = 1; i <= 23; i++) expect_val($sformatf("alu_r%0d", i), alu_exp[i]);
            expect_val("alu_pc", 32'h64);
            release_rst();
            run(24);
            for (int i = 1; i <= 23; i++) check(rf(i));
            check(pc);
        end

        // Array sum of 1..10, result stored at byte 40, then spin on j.
        begin_prog();
        for (int k = 0; k < 10; k++) dut.DataMemory[4*k+3] = 8'(k + 1);
        put(enc_i(6'h08, 0, 1, 0));
        put(enc_i(6'h08, 0, 2, 40));
        put(enc_i(6'h08, 0, 3, 0));
        put(enc_i(6'h23, 1, 4, 0));
        put(enc_r(3, 4, 3, 0, 6'h20));
        put(enc_i(6'h08, 1, 1, 4));
        put(enc_i(6'h05, 1, 2, -4));
        put(enc_i(6'h2B, 0, 3, 40));
        put(enc_j(6'h02, 8));
        expect_val("sum_dm40", 32'h37);
        expect_val("sum_spin_pc", 32'h20);
        expect_val("sum_spin_pc2", 32'h20);
        release_rst();
        run(50);
        check(dmw(40)); check(pc);
        run(5);
        check(pc);

        // Asynchronous reset between edges while spinning.
        #3;
        rst_n = 1'b0;
        #1;
        expect_val("async_pc", 32'h0);
        for (int i = 0; i < 32; i++) expect_val($sformatf("async_r%0d", i), 32'h0);
        expect_val("async_dm40", 32'h37);
        check(pc);
        for (int i = 0; i < 32; i++) check(rf(i));
        check(dmw(40));
        expect_val("held_pc", 32'h0);
        run(1);
        check(pc);
        expect_val("restart_pc", 32'hC);
        expect_val("restart_r2", 32'd40);
        expect_val("restart_dm40", 32'h37);
        release_rst();
        run(3);
        check(pc); check(rf(2)); check(dmw(40));

        // jal / jr, behaviour depends on build.
        begin_prog();
        put(enc_i(6'h08, 0, 5, 5));
        put(32'h0); put(32'h0); put(32'h0);
        put(enc_j(6'h03, 8));
        put(enc_i(6'h08, 0, 6, 6));
        put(32'h0); put(32'h0);
        put(enc_i(6'h08, 0, 7, 7));
        put(enc_r(31, 0, 0, 0, 6'h08));
`ifdef MIPS_CORE_JAL_EN
        expect_val("jal_pc", 32'h20);
        expect_val("jal_r31", 32'h14);
        expect_val("jr_pc", 32'h18);
        expect_val("jal_tgt_r7", 32'h7);
        expect_val("jr_ret_r6", 32'h6);
`else
        expect_val("jal_pc", 32'h14);
        expect_val("jal_r31", 32'h0);
        expect_val("jr_pc", 32'h20);
        expect_val("jal_tgt_r7", 32'h0);
        expect_val("jr_ret_r6", 32'h6);
`endif
        release_rst();
        run(5);
        check(pc); check(rf(31));
        run(3);
        check(pc); check(rf(7)); check(rf(6));

        if (sbq.size() != 0) begin
            n_fail++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_core.md
MIPS_CORE -- requirements
Module: mips_core

Interface
REQ-001 Parameter IM_WORDS, default 256: instruction memory depth in 32-bit words.
REQ-002 Parameter DM_BYTES, default 1024: data memory depth in bytes.
REQ-003 clk  input  1  single rising-edge clock for all state.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 pc  output  32  current program counter, byte address.

Function
REQ-006 Single-cycle datapath SHALL fetch, decode, execute and write back one instruction per rising clk edge.
REQ-007 Instruction memory SHALL be a word array indexed by pc[31:2] modulo IM_WORDS, read combinationally, with no write port.
REQ-008 Data memory SHALL be a byte array, big-endian: the word at address A is {M[A],M[A+1],M[A+2],M[A+3]}.
REQ-009 Data memory reads SHALL be combinational and writes synchronous; addresses wrap modulo DM_BYTES, with low two bits ignored (word aligned).
REQ-010 The supported set SHALL be R-type add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, plus addi, addiu, andi, ori, xori, slti, lui, lw, sw, beq, bne and j.
REQ-011 Arithmetic SHALL be 32-bit two's complement wrap with no overflow trap.
REQ-012 addi, addiu, slti, lw, sw, beq and bne SHALL sign-extend the immediate; andi, ori and xori SHALL zero-extend it.
REQ-013 Branch target SHALL be pc+4+(sext(imm)<<2); jump target SHALL be {pc+4[31:28],target,2'b00}; otherwise next pc = pc+4.
REQ-014 The register file SHALL have 32x32 registers with two combinational read ports and one synchronous write port.
REQ-015 Register $0 SHALL read as 0 and writes to it SHALL be discarded.
REQ-016 A read of a register written in the same cycle SHALL return the old value.
REQ-017 Unknown opcode or funct SHALL execute as a NOP (pc+4, no writes).
REQ-018 lw and sw in the same program SHALL be visible to each other: a lw in the cycle after a sw to the same address returns the new data.

Reset
REQ-019 While rst_n=0: pc=0 and all 32 registers=0, applied immediately and independent of clk.
REQ-020 Instruction and data memories SHALL NOT be cleared by reset.
REQ-021 Both memories SHALL be loadable before execution by hierarchical $readmemh into arrays named InstructionMemory (words) and DataMemory (bytes).
REQ-022 The first fetch after rst_n rises SHALL be from address 0.

Configuration
REQ-023 With macro MIPS_CORE_JAL_EN defined, jal SHALL write pc+4 to $31 and jump, and jr SHALL set pc=rs.
REQ-024 Without MIPS_CORE_JAL_EN, jal and jr SHALL decode as NOPs.

Structure
REQ-025 Package mips_core_pkg SHALL hold the opcode and funct localparams, the ALU-operation enum typedef, and the register index constants (ZERO=0, RA=31).
REQ-026 The register file SHALL be the one sub-module, mips_regfile, with storage array Registers; PC, memories, control and ALU stay in mips_core.

Verification
REQ-027 addi $8,$0,5; addi $9,$0,-3; add $10,$8,$9 -> $10=00000002, pc=0000000C.
REQ-028 DataMemory[0..3]=00,00,00,07; lw $11,0($0); sw $11,8($0) -> $11=00000007 and DataMemory[8..11]=00,00,00,07.
REQ-029 addi $0,$0,9; beq $0,$0,+2 -> $0=00000000 and the branch is taken from pc=4 to pc=0000000C.
REQ-030 Array-sum program over words 1..10 at bytes 0..36 -> word at byte 40 = 00000037, then the program spins at its final j.
REQ-031 rst_n pulsed low mid-program between clock edges -> pc and all registers are 0 immediately, and DataMemory is unchanged.
REQ-032 With MIPS_CORE_JAL_EN, jal at pc=0x10 -> $31=00000014 and the target executes; without the macro, pc=00000014.
